rob_req_issue: RTL and testbench
================================

// Module: rob_req_issue
// PURPOSE
//  Multi-channel request front-end of the ROB. Arbitrates NCH requester channels
//  onto one downstream request port and allocates a free ID tag per request.
//  Tracks outstanding tags until they are retired on the return port.
//  Successor to the single-channel request port: adds channels, tag management,
//  a selectable arbitration mode and an outstanding-request limit.
// PARAMETERS
//  NCH       4                 number of requester channels (>=1)
//  AWIDTH    rob_package       address width
//  IDWIDTH   rob_package       tag width; tag pool = 2**IDWIDTH
//  PWIDTH    rob_package       param width
//  DWIDTH    rob_package       data width
//  MAX_OUT   2**IDWIDTH        outstanding limit (1..2**IDWIDTH)
//  ARB_MODE  0                 0 = round-robin, 1 = fixed priority (ch0 highest)
// PORTS
//  clk           in   1                 single clock, rising edge
//  rst           in   1                 synchronous reset, active-high
//  in_val        in   NCH               per-channel request valid
//  in_addr       in   NCH*AWIDTH        per-channel address, ch i at [i*AWIDTH +: AWIDTH]
//  in_param      in   NCH*PWIDTH        per-channel param, same packing
//  in_data       in   NCH*DWIDTH        per-channel data, same packing
//  in_ready      out  NCH               per-channel accept, at most one bit set
//  out_val       out  1                 downstream request valid
//  out_addr      out  AWIDTH            registered address
//  out_param     out  PWIDTH            registered param
//  out_data      out  DWIDTH            registered data
//  out_ID        out  IDWIDTH           allocated tag
//  out_ch        out  max(1,$clog2(NCH)) source channel of the request
//  out_ready     in   1                 downstream accept
//  ret_val       in   1                 tag retire strobe
//  ret_ID        in   IDWIDTH           tag being retired
//  outstanding   out  IDWIDTH+1         count of allocated tags
//  full          out  1                 outstanding == MAX_OUT or no free tag
//  err_dbl_free  out  1                 sticky: a free tag was retired
// BEHAVIOUR
//  Reset (rst=1 at edge): out_val=0, out_* fields=0, tag bitmap all free,
//   rr pointer=0, outstanding=0, err_dbl_free=0. in_ready=0 while rst=1.
//  Reset mid-operation drops any held out_val request, frees all tags and
//   ignores ret_val in that cycle.
//  Output stage is one register. Required: slot_free = !out_val | out_ready.
//  grant_en = slot_free & !full & !rst. in_ready[i] = grant_en & (grant == i).
//  Arbitration is combinational over in_val.
//   RR mode: first valid channel at or after ptr, wrapping NCH-1 -> 0.
//   Fixed mode: lowest-index valid channel wins.
//  Transfer: in_val[i] & in_ready[i]. On that edge:
//   - Fields of ch i are captured, with out_ch=i.
//   - out_ID = lowest-index free tag in the registered bitmap; its bit is set.
//   - out_val=1. Latency is 1 cycle, in transfer to out_val.
//   - RR: ptr <= (i+1) mod NCH. ptr is unchanged when no transfer happens.
//  Back-to-back transfers at 1 per clk are required when out_ready=1 and tags are free.
//  out_val=1 & out_ready=0: all out_* fields are held stable and no new grant is made.
//  out_val=1 & out_ready=1 & no transfer: out_val <= 0 next edge.
//  Retire: ret_val=1 clears bit ret_ID at the edge; the tag is allocatable the next cycle.
//   Allocation never sees a same-cycle retire.
//  Retire of a tag whose bit is already clear: no state change to bitmap/outstanding,
//   and err_dbl_free <= 1, held until rst.
//  outstanding: +1 on transfer, -1 on valid retire, unchanged if both or neither.
//   Saturates at neither end, because it is bounded by construction.
//  full is combinational from registered state:
//   full = (outstanding == MAX_OUT) | (bitmap all set).
//  Boundaries:
//   - Last free tag: granted normally, then full=1 next cycle.
//   - Full with a retire in the same cycle: still no grant that cycle.
//   - NCH=1: no arbitration, out_ch=0.
//  No combinational path ret_* -> in_ready. Combinational path out_ready -> in_ready is allowed.
// TESTING
//  1 Reset: hold rst 2 clks with all in_val=1.
//    -> in_ready=0, out_val=0, outstanding=0, full=0.
//  2 NCH=4, RR mode, in_val=4'b1111, out_ready=1, no retire.
//    -> grants to ch 0,1,2,3,0 on consecutive clks; out_ID=0,1,2,3,4.
//  3 ARB_MODE=1, in_val=4'b1010 steady.
//    -> ch1 always granted; ch3 in_ready stays 0.
//  4 IDWIDTH=2, MAX_OUT=4, issue 4, then ret_val ID=2 in the cycle the 5th request waits.
//    -> full=1 that cycle, no grant; next cycle grant with out_ID=2.
//  5 out_ready=0 for 3 clks after a grant with addr=0xA5.
//    -> out_val=1 and out_addr=0xA5, out_ID stable; in_ready=0 throughout.
//  6 ret_val ID=3 while tag 3 is free.
//    -> err_dbl_free=1 next clk and sticky; outstanding unchanged.
//    Also: rst mid-burst -> all tags free, out_val=0.

Source files
------------

// File: rtl/rob_req_issue.sv
// rob_req_issue: multi-channel request front-end of the ROB.
// Arbitrates NCH requesters onto one registered downstream port, allocates the
// lowest free ID tag per request and tracks outstanding tags until retired.
module rob_req_issue #(
  parameter int NCH      = 4,
  parameter int AWIDTH   = 8,
  parameter int IDWIDTH  = 3,
  parameter int PWIDTH   = 4,
  parameter int DWIDTH   = 8,
  parameter int MAX_OUT  = 2**IDWIDTH,
  parameter int ARB_MODE = 0,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        in_val,
  input  logic [NCH*AWIDTH-1:0] in_addr,
  input  logic [NCH*PWIDTH-1:0] in_param,
  input  logic [NCH*DWIDTH-1:0] in_data,
  output logic [NCH-1:0]        in_ready,
  output logic                  out_val,
  output logic [AWIDTH-1:0]     out_addr,
  output logic [PWIDTH-1:0]     out_param,
  output logic [DWIDTH-1:0]     out_data,
  output logic [IDWIDTH-1:0]    out_ID,
  output logic [CHW-1:0]        out_ch,
  input  logic                  out_ready,
  input  logic                  ret_val,
  input  logic [IDWIDTH-1:0]    ret_ID,
  output logic [IDWIDTH:0]      outstanding,
  output logic                  full,
  output logic                  err_dbl_free
);

  localparam int NTAG = 1 << IDWIDTH;
  localparam logic [IDWIDTH:0] MAX_OUT_V = (IDWIDTH+1)'(MAX_OUT);

  logic                 r_val;
  logic [AWIDTH-1:0]    r_addr;
  logic [PWIDTH-1:0]    r_param;
  logic [DWIDTH-1:0]    r_data;
  logic [IDWIDTH-1:0]   r_id;
  logic [CHW-1:0]       r_ch;
  logic [NTAG-1:0]      r_bitmap;
  logic [CHW-1:0]       r_ptr;
  logic [IDWIDTH:0]     r_outst;
  logic                 r_err;

  logic                 w_full;
  logic                 w_slot_free;
  logic                 w_grant_en;
  logic                 w_any;
  logic                 w_xfer;
  logic [CHW-1:0]       w_grant;
  logic [CHW-1:0]       w_idx;
  logic [CHW-1:0]       w_ptr_nxt;
  logic [IDWIDTH-1:0]   w_free_id;
  logic                 w_ret_ok;
  logic                 w_ret_dbl;
  logic [NTAG-1:0]      w_set;
  logic [NTAG-1:0]      w_clr;

  // Full is derived only from registered state, so a same-cycle retire cannot unblock a grant.
  assign w_full      = (r_outst == MAX_OUT_V) | (&r_bitmap);
  assign w_slot_free = ~r_val | out_ready;
  assign w_grant_en  = w_slot_free & ~w_full & ~rst;
  assign w_xfer      = w_grant_en & w_any;
  assign in_ready    = w_xfer ? (NCH'(1) << w_grant) : '0;

  // Arbitration: search starts at the rr pointer, or at channel 0 in fixed-priority mode.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ARB_MODE == 1) w_idx = CHW'(k);
      else               w_idx = CHW'((int'(r_ptr) + k) % NCH);
      if (!w_any && in_val[w_idx]) begin
        w_any   = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  // Lowest-index free tag in the registered bitmap.
  always_comb begin
    w_free_id = '0;
    for (int t = NTAG-1; t >= 0; t--) begin
      if (!r_bitmap[t]) w_free_id = IDWIDTH'(t);
    end
  end

  assign w_ret_ok  = ret_val &  r_bitmap[ret_ID];
  assign w_ret_dbl = ret_val & ~r_bitmap[ret_ID];
  assign w_set     = w_xfer   ? (NTAG'(1) << w_free_id) : '0;
  assign w_clr     = w_ret_ok ? (NTAG'(1) << ret_ID)    : '0;
  assign w_ptr_nxt = (w_grant == CHW'(NCH-1)) ? '0 : w_grant + 1'b1;

  // Output register, tag bitmap, outstanding count, rr pointer and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_val    <= 1'b0;
      r_addr   <= '0;
      r_param  <= '0;
      r_data   <= '0;
      r_id     <= '0;
      r_ch     <= '0;
      r_bitmap <= '0;
      r_ptr    <= '0;
      r_outst  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_val   <= 1'b1;
        r_addr  <= in_addr[w_grant*AWIDTH +: AWIDTH];
        r_param <= in_param[w_grant*PWIDTH +: PWIDTH];
        r_data  <= in_data[w_grant*DWIDTH +: DWIDTH];
        r_id    <= w_free_id;
        r_ch    <= w_grant;
        r_ptr   <= w_ptr_nxt;
      end else if (out_ready) begin
        r_val <= 1'b0;
      end
      // Set and clear never hit the same bit: one targets a free tag, the other a busy one.
      r_bitmap <= (r_bitmap | w_set) & ~w_clr;
      case ({w_xfer, w_ret_ok})
        2'b10:   r_outst <= r_outst + 1'b1;
        2'b01:   r_outst <= r_outst - 1'b1;
        default: r_outst <= r_outst;
      endcase
      if (w_ret_dbl) r_err <= 1'b1;
    end
  end

  assign out_val      = r_val;
  assign out_addr     = r_addr;
  assign out_param    = r_param;
  assign out_data     = r_data;
  assign out_ID       = r_id;
  assign out_ch       = r_ch;
  assign outstanding  = r_outst;
  assign full         = w_full;
  assign err_dbl_free = r_err;

endmodule

// File: tb/tb_rob_req_issue.sv
// Bench for rob_req_issue: a round-robin instance (8 tags) and a fixed-priority
// instance (4 tags), directed corner sequences, a vector table, and a random run
// of the round-robin instance against a behavioural model.
module tb_rob_req_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_addr;
  logic [15:0] in_param;
  logic [31:0] in_data;

  logic [3:0] rr_in_val, rr_in_ready;
  logic       rr_out_val, rr_out_ready, rr_ret_val, rr_full, rr_err;
  logic [7:0] rr_out_addr, rr_out_data;
  logic [3:0] rr_out_param, rr_outstanding;
  logic [2:0] rr_out_ID, rr_ret_ID;
  logic [1:0] rr_out_ch;

  logic [3:0] fx_in_val, fx_in_ready;
  logic       fx_out_val, fx_out_ready, fx_ret_val, fx_full, fx_err;
  logic [7:0] fx_out_addr, fx_out_data;
  logic [3:0] fx_out_param;
  logic [2:0] fx_outstanding;
  logic [1:0] fx_out_ID, fx_ret_ID;
  logic [1:0] fx_out_ch;

  int tests = 0;
  int fails = 0;

  rob_req_issue #(.NCH(4), .AWIDTH(8), .IDWIDTH(3), .PWIDTH(4), .DWIDTH(8),
                  .MAX_OUT(8), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst(rst), .in_val(rr_in_val), .in_addr(in_addr),
    .in_param(in_param), .in_data(in_data), .in_ready(rr_in_ready),
    .out_val(rr_out_val), .out_addr(rr_out_addr), .out_param(rr_out_param),
    .out_data(rr_out_data), .out_ID(rr_out_ID), .out_ch(rr_out_ch),
    .out_ready(rr_out_ready), .ret_val(rr_ret_val), .ret_ID(rr_ret_ID),
    .outstanding(rr_outstanding), .full(rr_full), .err_dbl_free(rr_err));

  rob_req_issue #(.NCH(4), .AWIDTH(8), .IDWIDTH(2), .PWIDTH(4), .DWIDTH(8),
                  .MAX_OUT(4), .ARB_MODE(1)) u_fx (
    .clk(clk), .rst(rst), .in_val(fx_in_val), .in_addr(in_addr),
    .in_param(in_param), .in_data(in_data), .in_ready(fx_in_ready),
    .out_val(fx_out_val), .out_addr(fx_out_addr), .out_param(fx_out_param),
    .out_data(fx_out_data), .out_ID(fx_out_ID), .out_ch(fx_out_ch),
    .out_ready(fx_out_ready), .ret_val(fx_ret_val), .ret_ID(fx_ret_ID),
    .outstanding(fx_outstanding), .full(fx_full), .err_dbl_free(fx_err));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] val;
    logic [3:0] exp_ready;
  } vec_t;
  vec_t vecs[8];

  // behavioural model of the round-robin instance
  bit         m_busy[8];
  bit         m_val, m_err;
  logic [7:0] m_addr, m_data;
  logic [3:0] m_param;
  int         m_id, m_ch, m_ptr;
  int         cnt, win, fid, start, c;
  bit         en, xfer, picked;
  logic [3:0] exp_ready;

  task automatic model_reset();
    for (int t = 0; t < 8; t++) m_busy[t] = 1'b0;
    m_val = 0; m_err = 0; m_addr = 0; m_data = 0; m_param = 0;
    m_id = 0; m_ch = 0; m_ptr = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{4'b0000, 4'b0000};
    vecs[1] = '{4'b0001, 4'b0001};
    vecs[2] = '{4'b1010, 4'b0010};
    vecs[3] = '{4'b1100, 4'b0100};
    vecs[4] = '{4'b1000, 4'b1000};
    vecs[5] = '{4'b1111, 4'b0001};
    vecs[6] = '{4'b0110, 4'b0010};
    vecs[7] = '{4'b0101, 4'b0001};

    rst = 1; rr_in_val = 4'hF; fx_in_val = 4'hF;
    rr_out_ready = 1; fx_out_ready = 1;
    rr_ret_val = 0; rr_ret_ID = 0; fx_ret_val = 0; fx_ret_ID = 0;
    in_addr  = {8'h13, 8'h12, 8'h11, 8'h10};
    in_param = {4'h3, 4'h2, 4'h1, 4'h0};
    in_data  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};

    // reset held two clocks with every channel requesting
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rr_in_ready", int'(rr_in_ready), 0);
    chk("rst_fx_in_ready", int'(fx_in_ready), 0);
    chk("rst_rr_out_val", int'(rr_out_val), 0);
    chk("rst_rr_outstanding", int'(rr_outstanding), 0);
    chk("rst_rr_full", int'(rr_full), 0);
    chk("rst_fx_full", int'(fx_full), 0);

    // round-robin burst: ch 0,1,2,3,0 with tags 0..4
    @(negedge clk);
    rst = 0; fx_in_val = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("rr_burst_val", int'(rr_out_val), 1);
      chk("rr_burst_ch", int'(rr_out_ch), k % 4);
      chk("rr_burst_id", int'(rr_out_ID), k);
      chk("rr_burst_addr", int'(rr_out_addr), 8'h10 + (k % 4));
    end
    rr_in_val = 0; rr_out_ready = 0;
    @(negedge clk); #1;
    chk("rr_burst_outstanding", int'(rr_outstanding), 5);

    // reset mid-burst, with a retire that must be ignored
    rst = 1; rr_ret_val = 1; rr_ret_ID = 0;
    @(posedge clk); #1;
    rst = 0; rr_ret_val = 0;
    chk("midrst_out_val", int'(rr_out_val), 0);
    chk("midrst_outstanding", int'(rr_outstanding), 0);
    chk("midrst_full", int'(rr_full), 0);
    chk("midrst_err", int'(rr_err), 0);

    // fixed priority with ch1 and ch3 requesting: ch1 takes all four tags
    fx_in_val = 4'b1010; fx_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("fx_ready_ch1", int'(fx_in_ready), 4'b0010);
      @(posedge clk); #1;
      chk("fx_ch", int'(fx_out_ch), 1);
      chk("fx_id", int'(fx_out_ID), i);
    end

    // pool exhausted; a retire in the waiting cycle does not grant that cycle
    @(negedge clk); #1;
    chk("fx_full", int'(fx_full), 1);
    chk("fx_full_no_ready", int'(fx_in_ready), 0);
    fx_ret_val = 1; fx_ret_ID = 2;
    #1;
    chk("fx_ret_no_comb_ready", int'(fx_in_ready), 0);
    @(posedge clk); #1;
    fx_ret_val = 0;
    chk("fx_after_ret_val", int'(fx_out_val), 0);
    chk("fx_after_ret_outst", int'(fx_outstanding), 3);
    chk("fx_after_ret_full", int'(fx_full), 0);
    @(negedge clk); #1;
    chk("fx_regrant_ready", int'(fx_in_ready), 4'b0010);
    @(posedge clk); #1;
    chk("fx_regrant_id", int'(fx_out_ID), 2);
    chk("fx_regrant_val", int'(fx_out_val), 1);
    chk("fx_regrant_outst", int'(fx_outstanding), 4);
    fx_in_val = 0;

    // retire tag 3, then retire it again while free
    @(negedge clk); fx_ret_val = 1; fx_ret_ID = 3;
    @(posedge clk); #1; fx_ret_val = 0;
    chk("dbl_first_outst", int'(fx_outstanding), 3);
    chk("dbl_first_err", int'(fx_err), 0);
    @(negedge clk); fx_ret_val = 1; fx_ret_ID = 3;
    @(posedge clk); #1; fx_ret_val = 0;
    chk("dbl_err", int'(fx_err), 1);
    chk("dbl_outst", int'(fx_outstanding), 3);
    @(posedge clk); #1;
    chk("dbl_err_sticky", int'(fx_err), 1);

    // backpressure: grant ch2 (addr A5), then hold with out_ready low
    in_addr[23:16] = 8'hA5; rr_in_val = 4'b0100; rr_out_ready = 0;
    @(posedge clk); #1;
    chk("bp_val", int'(rr_out_val), 1);
    chk("bp_addr", int'(rr_out_addr), 8'hA5);
    chk("bp_ch", int'(rr_out_ch), 2);
    chk("bp_id", int'(rr_out_ID), 0);
    rr_in_val = 4'hF; in_addr[23:16] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("bp_no_ready", int'(rr_in_ready), 0);
      @(posedge clk); #1;
      chk("bp_hold_val", int'(rr_out_val), 1);
      chk("bp_hold_addr", int'(rr_out_addr), 8'hA5);
      chk("bp_hold_id", int'(rr_out_ID), 0);
    end
    @(negedge clk); rr_out_ready = 1; #1;
    chk("bp_release_ready", int'(rr_in_ready), 4'b1000);
    @(posedge clk); #1;
    chk("bp_release_ch", int'(rr_out_ch), 3);
    chk("bp_release_id", int'(rr_out_ID), 1);
    rr_in_val = 0;

    // vector table: combinational grant with both instances freshly reset
    @(negedge clk); rst = 1;
    @(posedge clk); #1; rst = 0; rr_out_ready = 1; fx_out_ready = 1;
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      rr_in_val = vecs[v].val; fx_in_val = vecs[v].val;
      #1;
      chk("tbl_rr_ready", int'(rr_in_ready), int'(vecs[v].exp_ready));
      chk("tbl_fx_ready", int'(fx_in_ready), int'(vecs[v].exp_ready));
      rr_in_val = 0; fx_in_val = 0;
    end

    // random run against the model
    @(negedge clk); rst = 1;
    @(posedge clk); #1; rst = 0;
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      rst          = ($urandom_range(0, 99) == 0);
      rr_in_val    = 4'($urandom);
      in_addr      = $urandom;
      in_param     = 16'($urandom);
      in_data      = $urandom;
      rr_out_ready = ($urandom_range(0, 3) != 0);
      rr_ret_val   = 0;
      rr_ret_ID    = 0;
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 24) == 0) begin
          rr_ret_val = 1; rr_ret_ID = 3'($urandom);
        end else begin
          start  = $urandom_range(0, 7);
          picked = 0;
          for (int k = 0; k < 8; k++) begin
            c = (start + k) % 8;
            if (!picked && m_busy[c]) begin
              picked = 1; rr_ret_val = 1; rr_ret_ID = 3'(c);
            end
          end
        end
      end
      #1;
      cnt = 0;
      for (int t = 0; t < 8; t++) cnt += int'(m_busy[t]);
      chk("rnd_out_val", int'(rr_out_val), int'(m_val));
      chk("rnd_outstanding", int'(rr_outstanding), cnt);
      chk("rnd_full", int'(rr_full), int'(cnt == 8));
      chk("rnd_err", int'(rr_err), int'(m_err));
      if (m_val) begin
        chk("rnd_addr", int'(rr_out_addr), int'(m_addr));
        chk("rnd_param", int'(rr_out_param), int'(m_param));
        chk("rnd_data", int'(rr_out_data), int'(m_data));
        chk("rnd_id", int'(rr_out_ID), m_id);
        chk("rnd_ch", int'(rr_out_ch), m_ch);
      end
      en  = !rst && (!m_val || rr_out_ready) && (cnt != 8);
      win = -1;
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (win < 0 && rr_in_val[c]) win = c;
      end
      xfer      = en && (win >= 0);
      exp_ready = xfer ? 4'(1 << win) : 4'b0000;
      chk("rnd_in_ready", int'(rr_in_ready), int'(exp_ready));
      if (rst) begin
        model_reset();
      end else begin
        fid = -1;
        for (int t = 0; t < 8; t++) if (fid < 0 && !m_busy[t]) fid = t;
        if (rr_ret_val) begin
          if (m_busy[rr_ret_ID]) m_busy[rr_ret_ID] = 0;
          else m_err = 1;
        end
        if (xfer) begin
          m_busy[fid] = 1;
          m_val   = 1;
          m_addr  = in_addr[win*8 +: 8];
          m_param = in_param[win*4 +: 4];
          m_data  = in_data[win*8 +: 8];
          m_id    = fid;
          m_ch    = win;
          m_ptr   = (win + 1) % 4;
        end else if (rr_out_ready) begin
          m_val = 0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
